// File: rtl/pixel_stream_if.sv
// pixel_stream_if: valid/ready bundle for pixel_stream_mux.
// master = stream source/sink side, slave = the mux itself.
interface pixel_stream_if #(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_CH-1:0]        s_valid;
  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [NUM_CH-1:0]        s_last;
  logic [NUM_CH-1:0]        s_ready;
  logic                     mode;
  logic [SEL_W-1:0]         fix_sel;
  logic                     m_valid;
  logic [DATA_W-1:0]        m_data;
  logic                     m_last;
  logic [SEL_W-1:0]         m_ch;
  logic                     m_ready;

  modport master (
    output s_valid, s_data, s_last, mode, fix_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_ch
  );

  modport slave (
    input  s_valid, s_data, s_last, mode, fix_sel, m_ready,
    output s_ready, m_valid, m_data, m_last, m_ch
  );
endinterface

// File: rtl/pixel_stream_mux.sv
// pixel_stream_mux: NUM_CH:1 registered valid/ready stream mux,
// round-robin or fixed-channel arbitration, one output register.
// Ports: clk, rst (sync active-high), bus (pixel_stream_if.slave):
//   s_valid/s_data/s_last/s_ready per channel, mode, fix_sel,
//   m_valid/m_data/m_last/m_ch/m_ready output stream.
// Option: define PIXEL_STREAM_MUX_PKT_LOCK_EN to hold the grant on
//   one channel from its first beat until its s_last beat.
module pixel_stream_mux #(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic         clk,
  input  logic         rst,
  pixel_stream_if.slave bus
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] grant;
  logic              load;
  logic              xfer;
  logic [SEL_W-1:0]  win;
  logic [DATA_W-1:0] wdata;
  logic              wlast;

`ifdef PIXEL_STREAM_MUX_PKT_LOCK_EN
  logic              locked;
  logic [SEL_W-1:0]  lock_ch;
`endif

  assign load = ~bus.m_valid | bus.m_ready;

  always_comb begin
    grant = '0;
    if (!bus.mode) begin
      // Walk from farthest to nearest so the nearest requester
      // after rr_ptr is the one left standing.
      for (int k = NUM_CH; k >= 1; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (i == (int'(rr_ptr) + k) % NUM_CH && bus.s_valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end
    end else begin
      // Out-of-range fix_sel matches no channel: no grant.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.fix_sel == SEL_W'(i)) grant[i] = bus.s_valid[i];
      end
    end
`ifdef PIXEL_STREAM_MUX_PKT_LOCK_EN
    if (locked) begin
      grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (lock_ch == SEL_W'(i)) grant[i] = bus.s_valid[i];
      end
    end
`endif
  end

  assign bus.s_ready = grant & {NUM_CH{load & ~rst}};
  assign xfer        = |bus.s_ready;

  always_comb begin
    win   = '0;
    wdata = '0;
    wlast = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        win   = SEL_W'(i);
        wdata = bus.s_data[i*DATA_W +: DATA_W];
        wlast = bus.s_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      bus.m_ch    <= '0;
      rr_ptr      <= SEL_W'(NUM_CH - 1);
    end else if (load) begin
      if (xfer) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= wdata;
        bus.m_last  <= wlast;
        bus.m_ch    <= win;
        rr_ptr      <= win;
      end else begin
        bus.m_valid <= 1'b0;
      end
    end
  end

`ifdef PIXEL_STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= ~wlast;
      lock_ch <= win;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_mux.sv
// tb_pixel_stream_mux: random + directed stimulus on a 4-channel and
// a 3-channel mux, checked every cycle against a transaction model.
module tb_pixel_stream_mux;

  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_stream_if #(.DATA_W(DW), .NUM_CH(4), .SEL_W(2)) if4 ();
  pixel_stream_if #(.DATA_W(DW), .NUM_CH(3), .SEL_W(2)) if3 ();

  pixel_stream_mux #(.DATA_W(DW), .NUM_CH(4), .SEL_W(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  pixel_stream_mux #(.DATA_W(DW), .NUM_CH(3), .SEL_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  typedef struct {
    bit          mv;
    bit [DW-1:0] md;
    bit          ml;
    int          mch;
    int          rr;
    bit          lk;
    int          lch;
  } mdl_t;

  mdl_t m4, m3;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the mux in transaction terms: pick the winner by the
  // arbitration rules, report ready, and advance the model state.
  function automatic void step(inout mdl_t m, input int n, input bit r,
                               input bit [3:0] v, input bit [4*DW-1:0] d,
                               input bit [3:0] l, input bit md,
                               input int fs, input bit mr,
                               output bit [3:0] rdy);
    int  g;
    bit  ld;
    rdy = '0;
    if (r) begin
      m.mv = 0; m.md = '0; m.ml = 0; m.mch = 0;
      m.rr = n - 1; m.lk = 0; m.lch = 0;
      return;
    end
    ld = !m.mv || mr;
    g  = -1;
    if (m.lk) begin
      if (v[m.lch]) g = m.lch;
    end else if (!md) begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (m.rr + k) % n;
        if (g < 0 && v[c]) g = c;
      end
    end else if (fs < n && v[fs]) begin
      g = fs;
    end
    if (!ld) return;
    if (g >= 0) begin
      rdy[g] = 1'b1;
      m.mv  = 1;
      m.md  = d[g*DW +: DW];
      m.ml  = l[g];
      m.mch = g;
      m.rr  = g;
`ifdef PIXEL_STREAM_MUX_PKT_LOCK_EN
      m.lk  = !l[g];
      m.lch = g;
`endif
    end else begin
      m.mv = 0;
    end
  endfunction

  task automatic check_out(input string p, input mdl_t m,
                           input logic mv, input logic [DW-1:0] mdat,
                           input logic ml, input logic [1:0] mc);
    check({p, " m_valid"}, 32'(mv), 32'(m.mv));
    check({p, " m_data"}, 32'(mdat), 32'(m.md));
    check({p, " m_last"}, 32'(ml), 32'(m.ml));
    check({p, " m_ch"}, 32'(mc), 32'(m.mch));
  endtask

  initial begin
    bit [3:0]      v, l, r4, r3;
    bit [4*DW-1:0] d;
    bit            md, mr, r;
    int            fs;
    int            ncyc;
    ncyc = 4000;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc > 0) begin
        check_out("ch4", m4, if4.m_valid, if4.m_data, if4.m_last,
                  if4.m_ch);
        check_out("ch3", m3, if3.m_valid, if3.m_data, if3.m_last,
                  if3.m_ch);
      end
      r  = 0;
      v  = 4'hf;
      d  = {24'd3, 24'd2, 24'd1, 24'd0};
      l  = 4'h0;
      md = 0;
      fs = 0;
      mr = 1;
      if (cyc < 3) begin
        r = 1;
      end else if (cyc < 13) begin
        // plain round-robin, data = channel index
      end else if (cyc < 18) begin
        mr = 0;
        d  = {4{24'hABCDEF}};
      end else if (cyc < 28) begin
        md = 1; fs = 2;
      end else if (cyc < 38) begin
        md = 1; fs = 3;
      end else if (cyc < 60) begin
        v = 4'b0111;
        l = (cyc % 4 == 3) ? 4'hf : 4'h0;
        d = {24'h33, 24'h22, 24'h11, 24'(cyc)};
      end else begin
        r  = ($urandom % 64) == 0;
        v  = 4'($urandom);
        d  = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
        l  = 4'($urandom) & 4'($urandom);
        md = ((cyc / 300) % 2) == 1;
        fs = int'($urandom % 4);
        mr = ($urandom % 4) != 0;
      end
      rst         = r;
      if4.s_valid = v;
      if4.s_data  = d;
      if4.s_last  = l;
      if4.mode    = md;
      if4.fix_sel = 2'(fs);
      if4.m_ready = mr;
      if3.s_valid = v[2:0];
      if3.s_data  = d[3*DW-1:0];
      if3.s_last  = l[2:0];
      if3.mode    = md;
      if3.fix_sel = 2'(fs);
      if3.m_ready = mr;
      #1;
      step(m4, 4, r, v, d, l, md, fs, mr, r4);
      step(m3, 3, r, {1'b0, v[2:0]}, d, l, md, fs, mr, r3);
      check("ch4 s_ready", 32'(if4.s_ready), 32'(r4));
      check("ch3 s_ready", 32'(if3.s_ready), 32'(r3[2:0]));
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
